dct_stage_sequencer: RTL and testbench

- Parametrised stage/index sequencer for memory-based multi-stage DCT datapaths. Generalises the fixed 4-stage × 8-point controller.
- Adds the following over the fixed controller: configurable stage/point counts, forward/inverse stage ordering, datapath stall, inter-stage pipeline drain gap, synchronous abort, back-to-back block starts and a completed-block counter.
- Drives the address generator and butterfly/ROM datapath; sits between the top-level stream control and the working-memory ports.

---
 rtl/dct_stage_sequencer_if.sv | 33 +++
 rtl/dct_stage_sequencer.sv | 136 +++++++++++++
 tb/tb_dct_stage_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_stage_sequencer_if.sv
// Control/status bundle between stream control and the DCT stage sequencer.
// The master side issues block requests; the slave side reports progress.
interface dct_stage_sequencer_if #(
    parameter int STAGE_W = 2,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               inverse;
    logic               stall;
    logic               abort;
    logic               busy;
    logic               step_valid;
    logic [STAGE_W-1:0] stage;
    logic [IDX_W-1:0]   index;
    logic               first;
    logic               last;
    logic               mode_q;
    logic               done;
    logic [CNT_W-1:0]   blk_cnt;

    modport master (
        output start, inverse, stall, abort,
        input  busy, step_valid, stage, index,
        input  first, last, mode_q, done, blk_cnt
    );

    modport slave (
        input  start, inverse, stall, abort,
        output busy, step_valid, stage, index,
        output first, last, mode_q, done, blk_cnt
    );
endinterface

// File: rtl/dct_stage_sequencer.sv
// Stage/index sequencer for memory-based multi-stage DCT datapaths.
// Walks NUM_STAGES x NUM_POINTS steps with optional drain gaps between stages.
module dct_stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int NUM_POINTS = 8,
    parameter int STAGE_W    = 2,
    parameter int IDX_W      = 3,
    parameter int DRAIN_CYC  = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dct_stage_sequencer_if.slave  bus
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_POINTS - 1);
    localparam logic [STAGE_W-1:0] STG_LAST = STAGE_W'(NUM_STAGES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT =
        DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               mode_r, mode_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               last_stage;
    logic [STAGE_W-1:0] stage_nxt;

    // Inverse blocks walk the stages downward, so their last stage is 0.
    assign last_stage = mode_r ? (stage_q == '0) : (stage_q == STG_LAST);
    assign stage_nxt  = mode_r ? stage_q - 1'b1 : stage_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            index_q <= '0;
            mode_r  <= 1'b0;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            index_q <= index_d;
            mode_r  <= mode_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        index_d = index_q;
        mode_d  = mode_r;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = IDLE;
            stage_d = '0;
            index_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        mode_d  = bus.inverse;
                        index_d = '0;
                        stage_d = bus.inverse ? STG_LAST : '0;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (index_q != IDX_LAST) begin
                            index_d = index_q + 1'b1;
                        end else if (last_stage) begin
                            state_d = DONE;
                            index_d = '0;
                        end else if (DRAIN_CYC > 0) begin
                            state_d = DRAIN;
                            drain_d = DRAIN_INIT;
                        end else begin
                            stage_d = stage_nxt;
                            index_d = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = RUN;
                        stage_d = stage_nxt;
                        index_d = '0;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                DONE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.start) begin
                        state_d = RUN;
                        mode_d  = bus.inverse;
                        index_d = '0;
                        stage_d = bus.inverse ? STG_LAST : '0;
                    end else begin
                        state_d = IDLE;
                        stage_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
    assign bus.step_valid = (state_q == RUN) && !bus.stall;
    assign bus.first      = bus.step_valid && (index_q == '0);
    assign bus.last       = bus.step_valid && (index_q == IDX_LAST);
    assign bus.done       = (state_q == DONE);
    assign bus.stage      = stage_q;
    assign bus.index      = index_q;
    assign bus.mode_q     = mode_r;
    assign bus.blk_cnt    = cnt_q;

endmodule

// File: tb/tb_dct_stage_sequencer.sv
// Directed bench for dct_stage_sequencer: three configurations
// (default, no-drain, 3x6 with one drain cycle) sharing clock and reset.
module tb_dct_stage_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_a;

    dct_stage_sequencer_if #(.STAGE_W(2), .IDX_W(3), .CNT_W(16)) ia ();
    dct_stage_sequencer_if #(.STAGE_W(2), .IDX_W(3), .CNT_W(16)) ib ();
    dct_stage_sequencer_if #(.STAGE_W(2), .IDX_W(3), .CNT_W(16)) ic ();

    dct_stage_sequencer u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    dct_stage_sequencer #(.DRAIN_CYC(0)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    dct_stage_sequencer #(
        .NUM_STAGES(3), .NUM_POINTS(6), .STAGE_W(2),
        .IDX_W(3), .DRAIN_CYC(1)
    ) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ic.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward default block: stage s occupies 10-cycle slots (8 steps + 2 drain).
    task automatic check_fwd_a(input string nm, input int c, input int p);
        int s;
        int o;
        logic v;
        logic [6:0] got;
        logic [6:0] want;
        s = p / 10;
        o = p % 10;
        v = (p < 38) && (o < 8);
        checks++;
        if (ia.step_valid !== v) begin
            errors++;
            $display("FAIL %s_valid c=%0d got %0b want %0b", nm, c, ia.step_valid, v);
        end
        if (v) begin
            got  = {ia.stage, ia.index, ia.first, ia.last};
            want = {2'(s), 3'(o), o == 0, o == 7};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_step c=%0d got %0h want %0h", nm, c, got, want);
            end
        end
    endtask

    task automatic test_reset();
        logic [27:0] got;
        @(negedge clk);
        #1;
        got = {ia.busy, ia.step_valid, ia.first, ia.last, ia.done,
               ia.mode_q, ia.stage, ia.index, ia.blk_cnt};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_a got %0h want 0", got);
        end
        got = {ic.busy, ic.step_valid, ic.first, ic.last, ic.done,
               ic.mode_q, ic.stage, ic.index, ic.blk_cnt};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_c got %0h want 0", got);
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        ia.start   = 1'b1;
        ia.inverse = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            ia.start = 1'b0;
            #1;
            if (c <= 39) check_fwd_a("fwd", c, c - 1);
            checks++;
            if (ia.done !== (c == 39)) begin
                errors++;
                $display("FAIL fwd_done c=%0d got %0b want %0b", c, ia.done, c == 39);
            end
        end
        exp_a++;
        checks++;
        if (ia.blk_cnt !== 16'(exp_a) || ia.busy !== 1'b0) begin
            errors++;
            $display("FAIL fwd_end cnt=%0d busy=%0b want cnt=%0d busy=0",
                     ia.blk_cnt, ia.busy, exp_a);
        end
    endtask

    task automatic test_inverse();
        int p;
        logic v;
        @(negedge clk);
        ib.start   = 1'b1;
        ib.inverse = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            ib.start   = 1'b0;
            ib.inverse = 1'b0;
            #1;
            p = c - 1;
            v = p < 32;
            checks++;
            if (ib.step_valid !== v || ib.done !== (c == 33)) begin
                errors++;
                $display("FAIL inv_ctl c=%0d got v=%0b d=%0b want v=%0b d=%0b",
                         c, ib.step_valid, ib.done, v, c == 33);
            end
            if (c <= 33) begin
                checks++;
                if (ib.mode_q !== 1'b1) begin
                    errors++;
                    $display("FAIL inv_mode c=%0d got %0b want 1", c, ib.mode_q);
                end
            end
            if (v) begin
                checks++;
                if (ib.stage !== 2'(3 - p / 8) || ib.index !== 3'(p % 8)) begin
                    errors++;
                    $display("FAIL inv_step c=%0d got %0d/%0d want %0d/%0d",
                             c, ib.stage, ib.index, 3 - p / 8, p % 8);
                end
            end
        end
        checks++;
        if (ib.blk_cnt !== 16'd1) begin
            errors++;
            $display("FAIL inv_cnt got %0d want 1", ib.blk_cnt);
        end
    endtask

    task automatic test_stall();
        logic st;
        @(negedge clk);
        ia.start   = 1'b1;
        ia.inverse = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            ia.start = 1'b0;
            st = (c >= 15) && (c <= 19);
            ia.stall = st;
            #1;
            if (st) begin
                checks++;
                if (ia.step_valid !== 1'b0 || ia.stage !== 2'd1 ||
                    ia.index !== 3'd4 || ia.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got v=%0b s=%0d i=%0d want v=0 s=1 i=4",
                             c, ia.step_valid, ia.stage, ia.index);
                end
            end else if (c <= 44) begin
                check_fwd_a("stall", c, (c >= 20) ? c - 6 : c - 1);
            end
            checks++;
            if (ia.done !== (c == 44)) begin
                errors++;
                $display("FAIL stall_done c=%0d got %0b want %0b", c, ia.done, c == 44);
            end
        end
        ia.stall = 1'b0;
        exp_a++;
        checks++;
        if (ia.blk_cnt !== 16'(exp_a)) begin
            errors++;
            $display("FAIL stall_cnt got %0d want %0d", ia.blk_cnt, exp_a);
        end
    endtask

    task automatic test_back_to_back();
        logic wd;
        @(negedge clk);
        ia.start   = 1'b1;
        ia.inverse = 1'b0;
        for (int c = 1; c <= 118; c++) begin
            @(negedge clk);
            if (c == 117) ia.start = 1'b0;
            #1;
            if (c <= 117) check_fwd_a("b2b", c, (c - 1) % 39);
            wd = (c == 39) || (c == 78) || (c == 117);
            checks++;
            if (ia.done !== wd) begin
                errors++;
                $display("FAIL b2b_done c=%0d got %0b want %0b", c, ia.done, wd);
            end
            if (c == 40 || c == 79) begin
                checks++;
                if (ia.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap c=%0d busy got %0b want 1", c, ia.busy);
                end
            end
        end
        exp_a += 3;
        checks++;
        if (ia.blk_cnt !== 16'(exp_a) || ia.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end cnt=%0d busy=%0b want cnt=%0d busy=0",
                     ia.blk_cnt, ia.busy, exp_a);
        end
    endtask

    task automatic test_abort();
        logic [5:0] got;
        @(negedge clk);
        ia.start   = 1'b1;
        ia.inverse = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            ia.start = 1'b0;
            if (c == 24) begin
                ia.abort = 1'b1;
                ia.start = 1'b1;
            end
            #1;
            check_fwd_a("abort_pre", c, c - 1);
        end
        checks++;
        if (ia.stage !== 2'd2 || ia.index !== 3'd3) begin
            errors++;
            $display("FAIL abort_pos got %0d/%0d want 2/3", ia.stage, ia.index);
        end
        for (int c = 25; c <= 45; c++) begin
            @(negedge clk);
            ia.abort = 1'b0;
            ia.start = 1'b0;
            #1;
            got = {ia.busy, ia.step_valid, ia.done, ia.stage, ia.index[0]};
            checks++;
            if (got !== '0 || ia.index !== 3'd0) begin
                errors++;
                $display("FAIL abort_idle c=%0d got %0h idx=%0d want 0", c, got, ia.index);
            end
        end
        checks++;
        if (ia.blk_cnt !== 16'(exp_a)) begin
            errors++;
            $display("FAIL abort_cnt got %0d want %0d", ia.blk_cnt, exp_a);
        end
    endtask

    task automatic test_small();
        int p;
        int s;
        int o;
        int nvalid;
        logic v;
        nvalid = 0;
        @(negedge clk);
        ic.start   = 1'b1;
        ic.inverse = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            ic.start = 1'b0;
            #1;
            p = c - 1;
            s = p / 7;
            o = p % 7;
            v = (p < 20) && (o < 6);
            if (ic.step_valid) nvalid++;
            checks++;
            if (ic.step_valid !== v || ic.done !== (c == 21)) begin
                errors++;
                $display("FAIL small_ctl c=%0d got v=%0b d=%0b want v=%0b d=%0b",
                         c, ic.step_valid, ic.done, v, c == 21);
            end
            if (v) begin
                checks++;
                if (ic.stage !== 2'(s) || ic.index !== 3'(o) ||
                    ic.last !== (o == 5)) begin
                    errors++;
                    $display("FAIL small_step c=%0d got %0d/%0d/%0b want %0d/%0d/%0b",
                             c, ic.stage, ic.index, ic.last, s, o, o == 5);
                end
            end
        end
        checks++;
        if (nvalid != 18 || ic.blk_cnt !== 16'd1) begin
            errors++;
            $display("FAIL small_total steps=%0d cnt=%0d want 18/1", nvalid, ic.blk_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [27:0] got;
        @(negedge clk);
        ic.start   = 1'b1;
        ic.inverse = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ic.start   = 1'b0;
            ic.inverse = 1'b0;
        end
        #1;
        checks++;
        if (ic.busy !== 1'b1 || ic.mode_q !== 1'b1 || ic.stage !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre busy=%0b mode=%0b stage=%0d want 1/1/1",
                     ic.busy, ic.mode_q, ic.stage);
        end
        #1;
        rst_n = 1'b0;
        #1;
        got = {ic.busy, ic.step_valid, ic.first, ic.last, ic.done,
               ic.mode_q, ic.stage, ic.index, ic.blk_cnt};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL rst_async got %0h want 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_a      = 0;
        rst_n      = 1'b0;
        ia.start   = 1'b0;
        ia.inverse = 1'b0;
        ia.stall   = 1'b0;
        ia.abort   = 1'b0;
        ib.start   = 1'b0;
        ib.inverse = 1'b0;
        ib.stall   = 1'b0;
        ib.abort   = 1'b0;
        ic.start   = 1'b0;
        ic.inverse = 1'b0;
        ic.stall   = 1'b0;
        ic.abort   = 1'b0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_forward();
        test_inverse();
        test_stall();
        test_back_to_back();
        test_abort();
        test_forward();
        test_small();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
